// File: rtl/bank_timing_tracker_pkg.sv
// rtl/bank_timing_tracker_pkg.sv - DRAM command and recode types plus default timing constants.
package bank_timing_tracker_pkg;

  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_ACT  = 3'd1,
    CMD_RD   = 3'd2,
    CMD_WR   = 3'd3,
    CMD_PRE  = 3'd4,
    CMD_PREA = 3'd5,
    CMD_REF  = 3'd6
  } dram_cmd_t;

  typedef enum logic [2:0] {
    CODE_IDLE                  = 3'd0,
    CODE_ACTIVE_TO_READ_WRITE  = 3'd1,
    CODE_READ_TO_PRECHARGE     = 3'd2,
    CODE_WRITE_TO_PRECHARGE    = 3'd3,
    CODE_PRECHARGE_TO_ACTIVE   = 3'd4,
    CODE_PRECHARGE_TO_REFRESH  = 3'd5
  } recode_state_t;

  localparam int DEF_CNT_W    = 6;
  localparam int DEF_T_RCD    = 4;
  localparam int DEF_T_RP     = 4;
  localparam int DEF_T_RAS    = 12;
  localparam int DEF_T_RTP    = 3;
  localparam int DEF_T_WR_TOT = 14;
  localparam int DEF_T_RRD    = 3;
  localparam int DEF_T_RFC    = 40;
  localparam int DEF_T_FAW    = 16;

endpackage

// File: rtl/bank_timing_tracker_bank_timer.sv
// rtl/bank_timing_tracker_bank_timer.sv - per-bank open flag, tRCD/tRP/precharge-window countdowns and recode.
module bank_timer
  import bank_timing_tracker_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int T_RCD    = DEF_T_RCD,
  parameter int T_RP     = DEF_T_RP,
  parameter int T_RAS    = DEF_T_RAS,
  parameter int T_RTP    = DEF_T_RTP,
  parameter int T_WR_TOT = DEF_T_WR_TOT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          do_act,
  input  logic          do_rd,
  input  logic          do_wr,
  input  logic          do_pre,
  input  logic          do_ref,
  output logic          open,
  output logic          rp_zero,
  output logic          act_rdy,
  output logic          rdwr_ok,
  output logic          pre_ok,
  output recode_state_t recode
);

  localparam logic [CNT_W-1:0] RCD_LD = CNT_W'(T_RCD - 1);
  localparam logic [CNT_W-1:0] RP_LD  = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] RAS_LD = CNT_W'(T_RAS - 1);
  localparam logic [CNT_W-1:0] RTP_LD = CNT_W'(T_RTP - 1);
  localparam logic [CNT_W-1:0] WR_LD  = CNT_W'(T_WR_TOT - 1);

  logic             open_q, open_d;
  logic [CNT_W-1:0] rcd_q, rcd_d;
  logic [CNT_W-1:0] rp_q, rp_d;
  logic [CNT_W-1:0] prew_q, prew_d, prew_dec;
  recode_state_t    recode_q, recode_d;

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? v : v - 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] max_cnt(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // The precharge window only ever extends: a short tRTP must not cut a pending tRAS/tWR.
  always_comb begin
    open_d   = open_q;
    rcd_d    = sat_dec(rcd_q);
    rp_d     = sat_dec(rp_q);
    prew_dec = sat_dec(prew_q);
    prew_d   = prew_dec;
    recode_d = recode_q;
    if (do_act) begin
      open_d   = 1'b1;
      rcd_d    = RCD_LD;
      prew_d   = max_cnt(prew_dec, RAS_LD);
      recode_d = CODE_ACTIVE_TO_READ_WRITE;
    end else if (do_rd) begin
      prew_d   = max_cnt(prew_dec, RTP_LD);
      recode_d = CODE_READ_TO_PRECHARGE;
    end else if (do_wr) begin
      prew_d   = max_cnt(prew_dec, WR_LD);
      recode_d = CODE_WRITE_TO_PRECHARGE;
    end else if (do_pre) begin
      open_d   = 1'b0;
      rp_d     = RP_LD;
      recode_d = CODE_PRECHARGE_TO_ACTIVE;
    end else if (do_ref) begin
      recode_d = CODE_PRECHARGE_TO_REFRESH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      open_q   <= 1'b0;
      rcd_q    <= '0;
      rp_q     <= '0;
      prew_q   <= '0;
      recode_q <= CODE_IDLE;
    end else begin
      open_q   <= open_d;
      rcd_q    <= rcd_d;
      rp_q     <= rp_d;
      prew_q   <= prew_d;
      recode_q <= recode_d;
    end
  end

  assign open    = open_q;
  assign rp_zero = (rp_q == '0);
  assign act_rdy = !open_q && (rp_q == '0);
  assign rdwr_ok = open_q && (rcd_q == '0);
  assign pre_ok  = open_q && (prew_q == '0);
  assign recode  = recode_q;

endmodule

// File: rtl/bank_timing_tracker.sv
// rtl/bank_timing_tracker.sv - rank-wide DRAM timing tracker: per-bank timers, tRRD/tRFC, legality and sticky viol.
// Optional four-activate window enabled by DRAM_TFAW_EN.
module bank_timing_tracker
  import bank_timing_tracker_pkg::*;
#(
  parameter int NUM_BANKS = 8,
  parameter int BA_W      = $clog2(NUM_BANKS),
  parameter int CNT_W     = DEF_CNT_W,
  parameter int T_RCD     = DEF_T_RCD,
  parameter int T_RP      = DEF_T_RP,
  parameter int T_RAS     = DEF_T_RAS,
  parameter int T_RTP     = DEF_T_RTP,
  parameter int T_WR_TOT  = DEF_T_WR_TOT,
  parameter int T_RRD     = DEF_T_RRD,
  parameter int T_RFC     = DEF_T_RFC,
  parameter int T_FAW     = DEF_T_FAW
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cmd_valid,
  input  dram_cmd_t                      cmd_type,
  input  logic [BA_W-1:0]                cmd_bank,
  output logic [NUM_BANKS-1:0]           act_ok,
  output logic [NUM_BANKS-1:0]           rdwr_ok,
  output logic [NUM_BANKS-1:0]           pre_ok,
  output logic                           ref_ok,
  output recode_state_t [NUM_BANKS-1:0]  recode,
  output logic                           viol
);

  if (T_RFC > (1 << CNT_W) || T_FAW > (1 << CNT_W)) begin : g_cnt_w_too_small
    $error("bank_timing_tracker: CNT_W too narrow for the configured timings");
  end

  localparam logic [CNT_W-1:0] RRD_LD = CNT_W'(T_RRD - 1);
  localparam logic [CNT_W-1:0] RFC_LD = CNT_W'(T_RFC - 1);

  logic                 is_act, is_rd, is_wr, is_pre, is_prea, is_ref;
  logic [NUM_BANKS-1:0] bank_sel;
  logic [NUM_BANKS-1:0] bank_open, bank_rp_zero, bank_act_rdy;
  logic [CNT_W-1:0]     rrd_q, rrd_d, rfc_q, rfc_d;
  logic                 viol_q, viol_d, cmd_illegal, faw_free;

  assign is_act   = cmd_valid && (cmd_type == CMD_ACT);
  assign is_rd    = cmd_valid && (cmd_type == CMD_RD);
  assign is_wr    = cmd_valid && (cmd_type == CMD_WR);
  assign is_pre   = cmd_valid && (cmd_type == CMD_PRE);
  assign is_prea  = cmd_valid && (cmd_type == CMD_PREA);
  assign is_ref   = cmd_valid && (cmd_type == CMD_REF);
  assign bank_sel = {{(NUM_BANKS-1){1'b0}}, 1'b1} << cmd_bank;

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    bank_timer #(
      .CNT_W    (CNT_W),
      .T_RCD    (T_RCD),
      .T_RP     (T_RP),
      .T_RAS    (T_RAS),
      .T_RTP    (T_RTP),
      .T_WR_TOT (T_WR_TOT)
    ) u_bank_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .do_act  (is_act && bank_sel[i]),
      .do_rd   (is_rd && bank_sel[i]),
      .do_wr   (is_wr && bank_sel[i]),
      .do_pre  ((is_pre && bank_sel[i]) || is_prea),
      .do_ref  (is_ref),
      .open    (bank_open[i]),
      .rp_zero (bank_rp_zero[i]),
      .act_rdy (bank_act_rdy[i]),
      .rdwr_ok (rdwr_ok[i]),
      .pre_ok  (pre_ok[i]),
      .recode  (recode[i])
    );
  end

`ifdef DRAM_TFAW_EN
  localparam logic [CNT_W-1:0] FAW_LD = CNT_W'(T_FAW - 1);

  logic [CNT_W-1:0] faw_q [4];
  logic [CNT_W-1:0] faw_d [4];
  logic             faw_taken;

  // Each ACT occupies the lowest idle window slot; with no slot idle the ACT is illegal.
  always_comb begin
    faw_taken = 1'b0;
    faw_free  = 1'b0;
    for (int j = 0; j < 4; j++) begin
      faw_d[j] = (faw_q[j] == '0) ? faw_q[j] : faw_q[j] - 1'b1;
      if (faw_q[j] == '0) begin
        faw_free = 1'b1;
        if (is_act && !faw_taken) begin
          faw_d[j]  = FAW_LD;
          faw_taken = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < 4; j++) faw_q[j] <= '0;
    end else begin
      for (int j = 0; j < 4; j++) faw_q[j] <= faw_d[j];
    end
  end
`else
  assign faw_free = 1'b1;
`endif

  assign act_ok = bank_act_rdy & {NUM_BANKS{(rrd_q == '0) && (rfc_q == '0) && faw_free}};
  assign ref_ok = !(|bank_open) && (&bank_rp_zero) && (rfc_q == '0);

  always_comb begin
    cmd_illegal = 1'b0;
    if (cmd_valid) begin
      case (cmd_type)
        CMD_ACT:        cmd_illegal = !act_ok[cmd_bank];
        CMD_RD, CMD_WR: cmd_illegal = !rdwr_ok[cmd_bank];
        CMD_PRE:        cmd_illegal = !pre_ok[cmd_bank];
        CMD_PREA:       cmd_illegal = |(bank_open & ~pre_ok);
        CMD_REF:        cmd_illegal = !ref_ok;
        default:        cmd_illegal = 1'b0;
      endcase
    end
  end

  always_comb begin
    rrd_d  = (rrd_q == '0) ? rrd_q : rrd_q - 1'b1;
    rfc_d  = (rfc_q == '0) ? rfc_q : rfc_q - 1'b1;
    viol_d = viol_q || cmd_illegal;
    if (is_act) rrd_d = RRD_LD;
    if (is_ref) rfc_d = RFC_LD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rrd_q  <= '0;
      rfc_q  <= '0;
      viol_q <= 1'b0;
    end else begin
      rrd_q  <= rrd_d;
      rfc_q  <= rfc_d;
      viol_q <= viol_d;
    end
  end

  assign viol = viol_q;

endmodule

// File: tb/tb_bank_timing_tracker.sv
// tb/tb_bank_timing_tracker.sv - directed bench with an absolute-time legality model and per-cycle compare.
module tb_bank_timing_tracker;
  import bank_timing_tracker_pkg::*;

  localparam int NB       = 8;
  localparam int BA       = 3;
  localparam int T_RCD    = 4;
  localparam int T_RP     = 4;
  localparam int T_RAS    = 12;
  localparam int T_RTP    = 3;
  localparam int T_WR_TOT = 14;
  localparam int T_RRD    = 3;
  localparam int T_RFC    = 40;
  localparam int T_FAW    = 16;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   cmd_valid;
  dram_cmd_t              cmd_type;
  logic [BA-1:0]          cmd_bank;
  logic [NB-1:0]          act_ok, rdwr_ok, pre_ok;
  logic                   ref_ok, viol;
  recode_state_t [NB-1:0] recode;

  always #5 clk = ~clk;

  bank_timing_tracker #(
    .NUM_BANKS (NB), .BA_W (BA), .CNT_W (6),
    .T_RCD (T_RCD), .T_RP (T_RP), .T_RAS (T_RAS), .T_RTP (T_RTP),
    .T_WR_TOT (T_WR_TOT), .T_RRD (T_RRD), .T_RFC (T_RFC), .T_FAW (T_FAW)
  ) dut (
    .clk (clk), .rst_n (rst_n), .cmd_valid (cmd_valid), .cmd_type (cmd_type),
    .cmd_bank (cmd_bank), .act_ok (act_ok), .rdwr_ok (rdwr_ok), .pre_ok (pre_ok),
    .ref_ok (ref_ok), .recode (recode), .viol (viol)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit check_en = 0;

  // Model: each timing is held as the absolute cycle at which the follow-on command becomes legal.
  bit            m_open [NB];
  int            m_rp_rdy [NB];
  int            m_rcd_rdy [NB];
  int            m_pre_rdy [NB];
  recode_state_t m_rec [NB];
  int            m_rrd_rdy, m_rfc_rdy;
  int            m_faw_rdy [4];
  bit            m_viol;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit m_faw_free(input int now);
`ifdef DRAM_TFAW_EN
    bit fr = 0;
    for (int j = 0; j < 4; j++) if (now >= m_faw_rdy[j]) fr = 1;
    return fr;
`else
    return 1'b1;
`endif
  endfunction

  function automatic bit m_act_ok(input int i, input int now);
    return !m_open[i] && now >= m_rp_rdy[i] && now >= m_rrd_rdy && now >= m_rfc_rdy && m_faw_free(now);
  endfunction

  function automatic bit m_rdwr_ok(input int i, input int now);
    return m_open[i] && now >= m_rcd_rdy[i];
  endfunction

  function automatic bit m_pre_ok(input int i, input int now);
    return m_open[i] && now >= m_pre_rdy[i];
  endfunction

  function automatic bit m_ref_ok(input int now);
    bit ok = now >= m_rfc_rdy;
    for (int i = 0; i < NB; i++) if (m_open[i] || now < m_rp_rdy[i]) ok = 0;
    return ok;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      m_open[i] = 0; m_rp_rdy[i] = 0; m_rcd_rdy[i] = 0; m_pre_rdy[i] = 0;
      m_rec[i] = CODE_IDLE;
    end
    for (int j = 0; j < 4; j++) m_faw_rdy[j] = 0;
    m_rrd_rdy = 0; m_rfc_rdy = 0; m_viol = 0;
  endtask

  task automatic model_apply(input dram_cmd_t c, input int b, input int now);
    bit legal = 1;
    bit placed = 0;
    case (c)
      CMD_ACT:        legal = m_act_ok(b, now);
      CMD_RD, CMD_WR: legal = m_rdwr_ok(b, now);
      CMD_PRE:        legal = m_pre_ok(b, now);
      CMD_PREA:       for (int i = 0; i < NB; i++) if (m_open[i] && !m_pre_ok(i, now)) legal = 0;
      CMD_REF:        legal = m_ref_ok(now);
      default:        legal = 1;
    endcase
    if (!legal) m_viol = 1;
    case (c)
      CMD_ACT: begin
        m_open[b] = 1;
        m_rcd_rdy[b] = now + T_RCD;
        if (now + T_RAS > m_pre_rdy[b]) m_pre_rdy[b] = now + T_RAS;
        m_rec[b] = CODE_ACTIVE_TO_READ_WRITE;
        m_rrd_rdy = now + T_RRD;
        for (int j = 0; j < 4; j++)
          if (!placed && now >= m_faw_rdy[j]) begin m_faw_rdy[j] = now + T_FAW; placed = 1; end
      end
      CMD_RD: begin
        if (now + T_RTP > m_pre_rdy[b]) m_pre_rdy[b] = now + T_RTP;
        m_rec[b] = CODE_READ_TO_PRECHARGE;
      end
      CMD_WR: begin
        if (now + T_WR_TOT > m_pre_rdy[b]) m_pre_rdy[b] = now + T_WR_TOT;
        m_rec[b] = CODE_WRITE_TO_PRECHARGE;
      end
      CMD_PRE: begin
        m_open[b] = 0; m_rp_rdy[b] = now + T_RP; m_rec[b] = CODE_PRECHARGE_TO_ACTIVE;
      end
      CMD_PREA: for (int i = 0; i < NB; i++) begin
        m_open[i] = 0; m_rp_rdy[i] = now + T_RP; m_rec[i] = CODE_PRECHARGE_TO_ACTIVE;
      end
      CMD_REF: begin
        m_rfc_rdy = now + T_RFC;
        for (int i = 0; i < NB; i++) m_rec[i] = CODE_PRECHARGE_TO_REFRESH;
      end
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      for (int i = 0; i < NB; i++) begin
        chk($sformatf("act_ok[%0d]", i), int'(act_ok[i]), int'(m_act_ok(i, cyc)));
        chk($sformatf("rdwr_ok[%0d]", i), int'(rdwr_ok[i]), int'(m_rdwr_ok(i, cyc)));
        chk($sformatf("pre_ok[%0d]", i), int'(pre_ok[i]), int'(m_pre_ok(i, cyc)));
        chk($sformatf("recode[%0d]", i), int'(recode[i]), int'(m_rec[i]));
      end
      chk("ref_ok", int'(ref_ok), int'(m_ref_ok(cyc)));
      chk("viol", int'(viol), int'(m_viol));
    end
  end

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic issue_raw(input bit v, input dram_cmd_t c, input int b);
    cmd_valid = v;
    cmd_type  = c;
    cmd_bank  = BA'(b);
    @(posedge clk);
    if (v) model_apply(c, b, cyc);
    cyc++;
    #1;
    cmd_valid = 1'b0;
    cmd_type  = CMD_NOP;
  endtask

  task automatic issue(input dram_cmd_t c, input int b);
    issue_raw(c != CMD_NOP, c, b);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  dram_cmd_t c;

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_type = CMD_NOP; cmd_bank = '0;
    model_reset();
    check_en = 1;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("reset_act_ok", int'(act_ok), 8'hFF);
    chk("reset_rdwr_ok", int'(rdwr_ok), 0);
    chk("reset_pre_ok", int'(pre_ok), 0);
    chk("reset_ref_ok", int'(ref_ok), 1);
    chk("reset_viol", int'(viol), 0);
    chk("reset_recode0", int'(recode[0]), int'(CODE_IDLE));

    // ACT bank2: tRCD, tRAS and tRRD; a cmd_type with cmd_valid low must be ignored
    for (int k = 0; k <= 12; k++) begin
      if (k >= 1 && k <= 3) chk("t1_rdwr2_early", int'(rdwr_ok[2]), 0);
      if (k == 4) chk("t1_rdwr2_ready", int'(rdwr_ok[2]), 1);
      if (k == 1 || k == 2) chk("t1_act3_rrd", int'(act_ok[3]), 0);
      if (k == 3) chk("t1_act3_ready", int'(act_ok[3]), 1);
      if (k == 6) chk("t1_invalid_ignored", int'(recode[3]), int'(CODE_IDLE));
      if (k == 11) chk("t1_pre2_early", int'(pre_ok[2]), 0);
      if (k == 12) chk("t1_pre2_ready", int'(pre_ok[2]), 1);
      if (k == 5) issue_raw(1'b0, CMD_ACT, 3);
      else issue(k == 0 ? CMD_ACT : CMD_NOP, 2);
    end

    // RD soon after ACT: tRAS still dominates
    do_reset();
    for (int k = 0; k <= 12; k++) begin
      if (k == 5) chk("t2_recode0_rd", int'(recode[0]), int'(CODE_READ_TO_PRECHARGE));
      if (k == 7 || k == 11) chk("t2_pre0_held", int'(pre_ok[0]), 0);
      if (k == 12) chk("t2_pre0_ready", int'(pre_ok[0]), 1);
      c = CMD_NOP;
      if (k == 0) c = CMD_ACT;
      if (k == 4) c = CMD_RD;
      issue(c, 0);
    end

    // WR window then PRE and tRP
    do_reset();
    for (int k = 0; k <= 22; k++) begin
      if (k == 17) chk("t3_pre1_early", int'(pre_ok[1]), 0);
      if (k == 18) chk("t3_pre1_ready", int'(pre_ok[1]), 1);
      if (k == 18) chk("t3_recode1_wr", int'(recode[1]), int'(CODE_WRITE_TO_PRECHARGE));
      if (k == 19) chk("t3_recode1_pre", int'(recode[1]), int'(CODE_PRECHARGE_TO_ACTIVE));
      if (k == 21) chk("t3_act1_early", int'(act_ok[1]), 0);
      if (k == 22) chk("t3_act1_ready", int'(act_ok[1]), 1);
      c = CMD_NOP;
      if (k == 0) c = CMD_ACT;
      if (k == 4) c = CMD_WR;
      if (k == 18) c = CMD_PRE;
      issue(c, 1);
    end

    // PREA then REF: tRP gates ref_ok, tRFC gates every ACT
    do_reset();
    issue(CMD_ACT, 5);
    repeat (11) issue(CMD_NOP, 0);
    chk("t4_pre5_ready", int'(pre_ok[5]), 1);
    for (int k = 0; k <= 44; k++) begin
      if (k == 3) chk("t4_ref_ok_rp", int'(ref_ok), 0);
      if (k == 4) chk("t4_ref_ok", int'(ref_ok), 1);
      if (k == 5 || k == 43) chk("t4_act_rfc", int'(act_ok), 0);
      if (k == 44) chk("t4_act_after_rfc", int'(act_ok), 8'hFF);
      if (k == 5)
        for (int i = 0; i < NB; i++)
          chk($sformatf("t4_recode_ref[%0d]", i), int'(recode[i]), int'(CODE_PRECHARGE_TO_REFRESH));
      c = CMD_NOP;
      if (k == 0) c = CMD_PREA;
      if (k == 4) c = CMD_REF;
      issue(c, 0);
    end

    // RD to closed bank sets sticky viol; async reset mid-tRFC clears everything
    do_reset();
    for (int k = 0; k <= 5; k++) begin
      if (k == 1 || k == 5) chk("t5_viol_sticky", int'(viol), 1);
      if (k == 5) chk("t5_ref_ok_rfc", int'(ref_ok), 0);
      c = CMD_NOP;
      if (k == 0) c = CMD_RD;
      if (k == 2) c = CMD_REF;
      issue(c, 6);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t5_async_viol", int'(viol), 0);
    chk("t5_async_act_ok", int'(act_ok), 8'hFF);
    chk("t5_async_ref_ok", int'(ref_ok), 1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("t5_post_ref_ok", int'(ref_ok), 1);
    chk("t5_post_act_ok", int'(act_ok), 8'hFF);

`ifdef DRAM_TFAW_EN
    // Four ACTs 3 cycles apart fill the window until the first slot expires
    do_reset();
    for (int k = 0; k <= 16; k++) begin
      if (k == 12 || k == 15) chk("t6_act4_faw", int'(act_ok[4]), 0);
      if (k == 16) chk("t6_act4_ready", int'(act_ok[4]), 1);
      c = CMD_NOP;
      if (k == 0 || k == 3 || k == 6 || k == 9) c = CMD_ACT;
      issue(c, k / 3);
    end
`endif

    check_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
